// File: rtl/ifetch_seq_pkg.sv
// ifetch_seq_pkg: shared widths, opcode constant and FSM state encoding for the fetch sequencer.
package ifetch_seq_pkg;
    localparam int DWIDTH_INST  = 32;
    localparam int DWIDTH_RFADD = 5;
    localparam int DEPTH_IMEM   = 1024;
    localparam logic [2:0] OP_BEQ = 3'b010;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_VEC, S_DONE} state_t;
endpackage

// File: rtl/ifetch_seq_if.sv
// ifetch_seq_if: program-load, decoder-feedback and issue signals between the sequencer and its environment.
interface ifetch_seq_if import ifetch_seq_pkg::*; #(
    parameter int dwidth_inst  = DWIDTH_INST,
    parameter int dwidth_RFadd = DWIDTH_RFADD,
    parameter int depth_imem   = DEPTH_IMEM
);
    localparam int dwidth_pc = $clog2(depth_imem);
    logic                    start;
    logic                    imem_wen;
    logic [dwidth_pc-1:0]    imem_waddr;
    logic [dwidth_inst-1:0]  imem_wdata;
    logic [dwidth_pc:0]      prog_len;
    logic                    is_vect;
    logic                    wen_ITR;
    logic [dwidth_RFadd-1:0] ITR;
    logic [2:0]              op_scalar;
    logic [11:0]             branch_immediate;
    logic                    branch_eq;
    logic [dwidth_inst-1:0]  instr;
    logic                    instr_valid;
    logic [dwidth_RFadd-1:0] elem_idx;
    logic [dwidth_pc-1:0]    pc;
    logic                    busy;
    logic                    done;
    modport master (
        output start, imem_wen, imem_waddr, imem_wdata, prog_len,
        output is_vect, wen_ITR, ITR, op_scalar, branch_immediate, branch_eq,
        input  instr, instr_valid, elem_idx, pc, busy, done
    );
    modport slave (
        input  start, imem_wen, imem_waddr, imem_wdata, prog_len,
        input  is_vect, wen_ITR, ITR, op_scalar, branch_immediate, branch_eq,
        output instr, instr_valid, elem_idx, pc, busy, done
    );
endinterface

// File: rtl/ifetch_seq_imem_bram.sv
// imem_bram: single write port, registered read port instruction store with one-cycle read latency.
module imem_bram #(
    parameter int dwidth = 32,
    parameter int depth  = 1024,
    localparam int awidth = $clog2(depth)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [awidth-1:0] waddr_i,
    input  logic [dwidth-1:0] wdata_i,
    input  logic              re_i,
    input  logic [awidth-1:0] raddr_i,
    output logic [dwidth-1:0] rdata_o
);
    logic [dwidth-1:0] mem_q [depth];
    logic [dwidth-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/ifetch_seq.sv
// ifetch_seq: fetches instructions from local memory and issues them, replaying vector ops once per element.
module ifetch_seq import ifetch_seq_pkg::*; #(
    parameter int dwidth_inst  = DWIDTH_INST,
    parameter int dwidth_RFadd = DWIDTH_RFADD,
    parameter int depth_imem   = DEPTH_IMEM
) (
    input logic        clk,
    input logic        rst,
    ifetch_seq_if.slave bus
);
    localparam int dwidth_pc = $clog2(depth_imem);
    localparam int W = dwidth_pc + 2;
    localparam logic [dwidth_pc-1:0]    PC_ONE = dwidth_pc'(1);
    localparam logic [dwidth_RFadd-1:0] VL_ONE = dwidth_RFadd'(1);
    state_t                  state_q, state_d;
    logic [dwidth_pc-1:0]    pc_q, pc_d, pc_nx;
    logic [dwidth_RFadd-1:0] vl_q, vl_d, elem_q, elem_d;
    logic                    valid, idle_like, vec_last, taken, br_out;
    logic signed [11:0]      imm_s;
    logic signed [W-1:0]     tgt;
    logic [dwidth_inst-1:0]  rdata;
    assign idle_like = state_q == S_IDLE || state_q == S_DONE;
    assign pc_nx     = pc_q + PC_ONE;
    assign vec_last  = elem_q == vl_q - VL_ONE;
    assign taken     = bus.op_scalar == OP_BEQ && bus.branch_eq;
    // Immediate is in halfwords; the arithmetic shift turns it into a signed word offset.
    assign imm_s  = bus.branch_immediate;
    assign tgt    = $signed({2'b00, pc_q}) + W'(imm_s >>> 1);
    assign br_out = tgt[W-1] || tgt >= $signed({1'b0, bus.prog_len});
    imem_bram #(.dwidth(dwidth_inst), .depth(depth_imem)) u_imem (
        .clk    (clk),
        .we_i   (bus.imem_wen && idle_like),
        .waddr_i(bus.imem_waddr),
        .wdata_i(bus.imem_wdata),
        .re_i   (state_q == S_FETCH),
        .raddr_i(pc_q),
        .rdata_o(rdata)
    );
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vl_d    = vl_q;
        elem_d  = elem_q;
        valid   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (bus.start) begin
                state_d = S_FETCH;
                pc_d    = '0;
                elem_d  = '0;
            end
            S_FETCH: state_d = ({1'b0, pc_q} >= bus.prog_len) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                valid = !(bus.is_vect && vl_q == '0);
                if (bus.wen_ITR) begin
                    vl_d    = bus.ITR;
                    pc_d    = pc_nx;
                    state_d = S_FETCH;
                end else if (bus.is_vect && vl_q > VL_ONE) begin
                    elem_d  = VL_ONE;
                    state_d = S_VEC;
                end else if (taken) begin
                    pc_d    = br_out ? pc_q : tgt[dwidth_pc-1:0];
                    state_d = br_out ? S_DONE : S_FETCH;
                end else begin
                    pc_d    = pc_nx;
                    state_d = S_FETCH;
                end
            end
            S_VEC: begin
                valid   = 1'b1;
                elem_d  = vec_last ? '0 : elem_q + VL_ONE;
                pc_d    = vec_last ? pc_nx : pc_q;
                state_d = vec_last ? S_FETCH : S_VEC;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            vl_q    <= VL_ONE;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vl_q    <= vl_d;
            elem_q  <= elem_d;
        end
    end
    assign bus.instr       = (state_q == S_ISSUE || state_q == S_VEC) ? rdata : '0;
    assign bus.instr_valid = valid;
    assign bus.elem_idx    = elem_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = !idle_like;
    assign bus.done        = state_q == S_DONE;
endmodule
